// File: rtl/pg_read_flush_tracker.sv
// Outstanding host-read tracker and read-path quiesce sequencer for port reset.
// Counts accepted read requests against final completions, gates new reads
// while a flush is in progress or the tracker is full, and reports when the
// read path has drained (or the drain timer has expired).
module pg_read_flush_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 256,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
  parameter int unsigned TIMEOUT_CYCLES  = 65536,
  parameter int unsigned TMR_WIDTH       = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_flush_req,
  input  logic                 i_rd_req,
  input  logic                 i_rd_cpl_last,
  output logic                 o_rd_block,
  output logic                 o_read_flush_done,
  output logic                 o_flush_timeout,
  output logic [CNT_WIDTH-1:0] o_outstanding,
  output logic                 o_cnt_err
);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [TMR_WIDTH-1:0] TMR_LAST = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_WIDTH-1:0] TMR_ONE  = TMR_WIDTH'(1);

  state_t               state;
  logic [TMR_WIDTH-1:0] timer;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 overflow;
  logic                 underflow;
  logic                 full_next;

  // Next in-flight count; a request and a completion in the same cycle cancel,
  // and the count saturates at both ends instead of wrapping.
  always_comb begin
    overflow  = i_rd_req && !i_rd_cpl_last && (cnt == CNT_MAX);
    underflow = i_rd_cpl_last && !i_rd_req && (cnt == '0);
    cnt_next  = cnt;
    if (i_rd_req && !i_rd_cpl_last && !overflow) begin
      cnt_next = cnt + CNT_ONE;
    end else if (i_rd_cpl_last && !i_rd_req && !underflow) begin
      cnt_next = cnt - CNT_ONE;
    end
    full_next = (cnt_next == CNT_MAX);
  end

  // Outstanding read counter; keeps counting in every flush state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // Sticky counter error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cnt_err <= 1'b0;
    end else if (overflow || underflow) begin
      o_cnt_err <= 1'b1;
    end
  end

  assign o_outstanding = cnt;

  // Flush sequencer with registered outputs; o_rd_block is assigned from the
  // state being entered so it tracks (next_state != IDLE) || full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      timer             <= '0;
      o_rd_block        <= 1'b0;
      o_read_flush_done <= 1'b0;
      o_flush_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_read_flush_done <= 1'b0;
          o_flush_timeout   <= 1'b0;
          timer             <= '0;
          if (i_flush_req) begin
            state      <= DRAIN;
            o_rd_block <= 1'b1;
          end else begin
            o_rd_block <= full_next;
          end
        end
        DRAIN: begin
          if (!i_flush_req) begin
            state      <= IDLE;
            timer      <= '0;
            o_rd_block <= full_next;
          end else if (cnt == '0) begin
            state             <= DONE;
            timer             <= '0;
            o_rd_block        <= 1'b1;
            o_read_flush_done <= 1'b1;
            o_flush_timeout   <= 1'b0;
          end else if (timer == TMR_LAST) begin
            state             <= DONE;
            timer             <= '0;
            o_rd_block        <= 1'b1;
            o_read_flush_done <= 1'b1;
            o_flush_timeout   <= 1'b1;
          end else begin
            timer      <= timer + TMR_ONE;
            o_rd_block <= 1'b1;
          end
        end
        DONE: begin
          if (!i_flush_req) begin
            state             <= IDLE;
            o_rd_block        <= full_next;
            o_read_flush_done <= 1'b0;
            o_flush_timeout   <= 1'b0;
          end else begin
            o_rd_block <= 1'b1;
          end
        end
        default: begin
          state             <= IDLE;
          timer             <= '0;
          o_rd_block        <= 1'b0;
          o_read_flush_done <= 1'b0;
          o_flush_timeout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pg_read_flush_tracker.sv
// Directed bench for pg_read_flush_tracker. A short-timeout instance covers
// most behaviour; a default-parameter instance covers the slow drain case.
module tb_pg_read_flush_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       rd_req;
  logic       cpl;

  logic       blk, done, tmo, err;
  logic [8:0] outst;
  logic       blk_l, done_l, tmo_l, err_l;
  logic [8:0] outst_l;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pg_read_flush_tracker #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_flush_req       (flush),
    .i_rd_req          (rd_req),
    .i_rd_cpl_last     (cpl),
    .o_rd_block        (blk),
    .o_read_flush_done (done),
    .o_flush_timeout   (tmo),
    .o_outstanding     (outst),
    .o_cnt_err         (err)
  );

  pg_read_flush_tracker dut_l (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_flush_req       (flush),
    .i_rd_req          (rd_req),
    .i_rd_cpl_last     (cpl),
    .o_rd_block        (blk_l),
    .o_read_flush_done (done_l),
    .o_flush_timeout   (tmo_l),
    .o_outstanding     (outst_l),
    .o_cnt_err         (err_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    flush  = 1'b0;
    rd_req = 1'b0;
    cpl    = 1'b0;
    #12;
    check("rst_blk", 32'(blk), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tmo", 32'(tmo), 0);
    check("rst_outst", 32'(outst), 0);
    check("rst_err", 32'(err), 0);
    check("rst_done_l", 32'(done_l), 0);
    #10 rst_n = 1'b1;
    tick();

    // balanced traffic
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bal_up", 32'(outst), 32'(i + 1));
    end
    rd_req = 1'b0;
    cpl    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bal_dn", 32'(outst), 32'(4 - i));
    end
    rd_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bal_both", 32'(outst), 0);
    end
    rd_req = 1'b0;
    cpl    = 1'b0;
    check("bal_err", 32'(err), 0);
    check("bal_blk", 32'(blk), 0);

    // idle flush
    flush = 1'b1;
    tick();
    check("idle_blk", 32'(blk), 1);
    check("idle_done_early", 32'(done), 0);
    tick();
    check("idle_done", 32'(done), 1);
    check("idle_tmo", 32'(tmo), 0);
    check("idle_blk2", 32'(blk), 1);
    flush = 1'b0;
    tick();
    check("idle_rel_blk", 32'(blk), 0);
    check("idle_rel_done", 32'(done), 0);
    check("idle_rel_tmo", 32'(tmo), 0);

    // drain with traffic, completions 20 cycles apart (default-timeout instance)
    rd_req = 1'b1;
    ticks(3);
    rd_req = 1'b0;
    check("drn_outst", 32'(outst_l), 3);
    flush = 1'b1;
    tick();
    check("drn_blk", 32'(blk_l), 1);
    for (int c = 0; c < 3; c++) begin
      ticks(19);
      check("drn_wait_done", 32'(done_l), 0);
      cpl = 1'b1;
      tick();
      cpl = 1'b0;
    end
    check("drn_zero", 32'(outst_l), 0);
    check("drn_done_early", 32'(done_l), 0);
    tick();
    check("drn_done", 32'(done_l), 1);
    check("drn_tmo", 32'(tmo_l), 0);
    check("drn_short_done", 32'(done), 1);
    check("drn_short_tmo", 32'(tmo), 1);
    check("drn_short_err", 32'(err), 0);
    flush = 1'b0;
    tick();
    check("drn_rel_done", 32'(done_l), 0);
    check("drn_rel_blk", 32'(blk_l), 0);
    check("drn_rel_short_tmo", 32'(tmo), 0);

    // timeout with one read stuck
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("tmo_outst", 32'(outst), 1);
    flush = 1'b1;
    tick();
    check("tmo_blk", 32'(blk), 1);
    ticks(15);
    check("tmo_done_early", 32'(done), 0);
    tick();
    check("tmo_done", 32'(done), 1);
    check("tmo_flag", 32'(tmo), 1);
    cpl = 1'b1;
    tick();
    cpl = 1'b0;
    check("tmo_late_outst", 32'(outst), 0);
    check("tmo_late_err", 32'(err), 0);
    check("tmo_late_done", 32'(done), 1);
    flush = 1'b0;
    tick();
    check("tmo_rel_done", 32'(done), 0);
    check("tmo_rel_flag", 32'(tmo), 0);
    check("tmo_rel_blk", 32'(blk), 0);

    // abort mid-drain
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    flush = 1'b1;
    tick();
    check("abt_blk", 32'(blk), 1);
    ticks(3);
    flush = 1'b0;
    tick();
    check("abt_blk_rel", 32'(blk), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abt_no_done", 32'(done), 0);
    end
    cpl = 1'b1;
    tick();
    cpl = 1'b0;
    check("abt_outst", 32'(outst), 0);

    // asynchronous reset while in DONE
    flush = 1'b1;
    ticks(2);
    check("ar_done", 32'(done), 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_done0", 32'(done), 0);
    check("ar_blk0", 32'(blk), 0);
    check("ar_tmo0", 32'(tmo), 0);
    check("ar_outst0", 32'(outst), 0);
    flush = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    check("ar_post_done", 32'(done), 0);
    check("ar_post_blk", 32'(blk), 0);

    // saturation
    rd_req = 1'b1;
    ticks(255);
    check("sat_255", 32'(outst), 255);
    check("sat_255_blk", 32'(blk), 0);
    tick();
    check("sat_256", 32'(outst), 256);
    check("sat_256_blk", 32'(blk), 1);
    check("sat_256_err", 32'(err), 0);
    tick();
    check("sat_257", 32'(outst), 256);
    check("sat_257_err", 32'(err), 1);
    check("sat_257_blk", 32'(blk), 1);
    rd_req = 1'b0;
    cpl    = 1'b1;
    tick();
    cpl = 1'b0;
    check("sat_dec", 32'(outst), 255);
    check("sat_dec_blk", 32'(blk), 0);
    check("sat_sticky", 32'(err), 1);

    // underflow after reset
    #3 rst_n = 1'b0;
    #1;
    check("uf_rst_err", 32'(err), 0);
    #1 rst_n = 1'b1;
    cpl = 1'b1;
    tick();
    cpl = 1'b0;
    check("uf_outst", 32'(outst), 0);
    check("uf_err", 32'(err), 1);
    check("uf_blk", 32'(blk), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
